// File: rtl/swim_host_ctrl.sv
// SWIM host command sequencer: plays the SWIM entry pattern or pulses NRST,
// then returns one status byte per command over a valid/ready stream.
module swim_host_ctrl #(
   parameter int TICK_DIV      = 6000,
   parameter int RST_TICKS     = 16,
   parameter int TIMEOUT_TICKS = 255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   input  logic       swim_in,
   output logic       swim_out,
   output logic       swim_oe,
   output logic       nrst_out,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTRY,
      S_WAIT_SYNC,
      S_NRST,
      S_RESP
   } state_t;

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
   localparam logic [7:0] RST_LAST = 8'(RST_TICKS - 1);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_TICKS - 1);
   localparam logic [7:0] BIT_LAST = 8'd35;
   localparam logic [35:0] PATTERN =
      36'b1111_1111_0011_0011_0011_0011_0101_0101_0111;

   state_t        r_state;
   logic [TW-1:0] r_tick_cnt;
   logic [7:0]    r_cnt;
   logic [35:0]   r_pat;
   logic          r_err;
   logic          r_entry_done;
   logic          r_swim_s1;
   logic          r_swim_s2;
   logic          r_swim_out;
   logic          r_swim_oe;
   logic          r_nrst_out;
   logic          r_rsp_valid;
   logic [7:0]    r_rsp_data;

   logic w_idle;
   logic w_accept;
   logic w_tick;
   logic w_swim_s;

   assign w_idle   = (r_state == S_IDLE);
   assign w_accept = cmd_valid & w_idle;
   assign w_tick   = (r_tick_cnt == TICK_MAX);
   assign w_swim_s = r_swim_s2;

   assign cmd_ready = w_idle;
   assign busy      = ~w_idle;
   assign rsp_data  = r_rsp_data;
   assign rsp_valid = r_rsp_valid;
   assign swim_out  = r_swim_out;
   assign swim_oe   = r_swim_oe;
   assign nrst_out  = r_nrst_out;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_tick_cnt   <= '0;
         r_cnt        <= '0;
         r_pat        <= '0;
         r_err        <= 1'b0;
         r_entry_done <= 1'b0;
         r_swim_s1    <= 1'b1;
         r_swim_s2    <= 1'b1;
         r_swim_out   <= 1'b1;
         r_swim_oe    <= 1'b0;
         r_nrst_out   <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
      end else begin
         r_swim_s1 <= swim_in;
         r_swim_s2 <= r_swim_s1;
         // Clearing on acceptance aligns every tick to the command start
         if (w_accept || w_tick) r_tick_cnt <= '0;
         else r_tick_cnt <= r_tick_cnt + TW'(1);
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_cnt <= '0;
                  case (cmd_data)
                     8'h00: begin
                        r_rsp_data  <= 8'hA0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                     end
                     8'h01: begin
                        r_swim_oe  <= 1'b1;
                        r_swim_out <= PATTERN[35];
                        r_pat      <= {PATTERN[34:0], 1'b0};
                        r_state    <= S_ENTRY;
                     end
                     8'h02: begin
                        r_nrst_out <= 1'b0;
                        r_state    <= S_NRST;
                     end
                     8'h03: begin
                        r_rsp_data  <= {4'h5, 1'b0, r_err,
                                        r_entry_done, w_swim_s};
                        r_err       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                     end
                     default: begin
                        r_rsp_data  <= 8'hEE;
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                     end
                  endcase
               end
            end
            S_ENTRY: begin
               if (w_tick) begin
                  if (r_cnt == BIT_LAST) begin
                     r_swim_oe  <= 1'b0;
                     r_swim_out <= 1'b1;
                     r_cnt      <= '0;
                     r_state    <= S_WAIT_SYNC;
                  end else begin
                     r_cnt      <= r_cnt + 8'd1;
                     r_swim_out <= r_pat[35];
                     r_pat      <= {r_pat[34:0], 1'b0};
                  end
               end
            end
            S_WAIT_SYNC: begin
               if (!w_swim_s) begin
                  r_entry_done <= 1'b1;
                  r_rsp_data   <= 8'hA1;
                  r_rsp_valid  <= 1'b1;
                  r_state      <= S_RESP;
               end else if (w_tick) begin
                  if (r_cnt == TO_LAST) begin
                     r_err        <= 1'b1;
                     r_entry_done <= 1'b0;
                     r_rsp_data   <= 8'hE1;
                     r_rsp_valid  <= 1'b1;
                     r_state      <= S_RESP;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
            end
            S_NRST: begin
               if (w_tick) begin
                  if (r_cnt == RST_LAST) begin
                     r_nrst_out   <= 1'b1;
                     r_entry_done <= 1'b0;
                     r_rsp_data   <= 8'hA2;
                     r_rsp_valid  <= 1'b1;
                     r_state      <= S_RESP;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
